// File: rtl/line_drawer_arbiter_pkg.sv
// Shared definitions for the line drawer arbiter: width derivations,
// coordinate types and the arbiter FSM state encoding.
package line_drawer_arbiter_pkg;

  function automatic int x_width(input int hor_pixels);
    return $clog2(hor_pixels);
  endfunction

  function automatic int y_width(input int ver_pixels);
    return $clog2(ver_pixels);
  endfunction

  // A single requester would still need a 1-bit index to keep ports legal.
  function automatic int id_width(input int requesters);
    return (requesters > 1) ? $clog2(requesters) : 1;
  endfunction

  localparam int X_WIDTH_DEF = x_width(640);
  localparam int Y_WIDTH_DEF = y_width(480);

  typedef logic [X_WIDTH_DEF-1:0] x_coord_t;
  typedef logic [Y_WIDTH_DEF-1:0] y_coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_1 = 2'd1,
    ST_WAIT_2 = 2'd2
  } state_t;

endpackage

// File: rtl/line_drawer_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from (last+1) mod N
// and reports the first asserted request.
module rr_picker
  import line_drawer_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] winner_o,
  output logic          found_o
);

  logic [IW-1:0] idx;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    // Offset N wraps back to last itself, so the previous winner is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!found_o && req_i[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_drawer_arbiter.sv
// Round-robin arbiter letting several line sources share one line drawer.
// Handshake: req_valid is a level held with stable coords until req_ack pulses.
module line_drawer_arbiter
  import line_drawer_arbiter_pkg::*;
#(
  parameter  int HOR_ACTIVE_PIXELS = 640,
  parameter  int VER_ACTIVE_PIXELS = 480,
  parameter  int REQUESTERS        = 2,
  localparam int X_WIDTH           = x_width(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH           = y_width(VER_ACTIVE_PIXELS),
  localparam int ID_WIDTH          = id_width(REQUESTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQUESTERS-1:0]         req_valid,
  input  logic [REQUESTERS*X_WIDTH-1:0] req_x1,
  input  logic [REQUESTERS*X_WIDTH-1:0] req_x2,
  input  logic [REQUESTERS*Y_WIDTH-1:0] req_y1,
  input  logic [REQUESTERS*Y_WIDTH-1:0] req_y2,
  output logic [REQUESTERS-1:0]         req_ack,
  output logic [REQUESTERS-1:0]         req_done,
  output logic [X_WIDTH-1:0]            x1,
  output logic [X_WIDTH-1:0]            x2,
  output logic [Y_WIDTH-1:0]            y1,
  output logic [Y_WIDTH-1:0]            y2,
  output logic                          line_drawer_start,
  input  logic                          line_drawer_ready,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic [1:0]                    dbg_state
);

  state_t                  state_q;
  logic [X_WIDTH-1:0]      x1_q, x2_q;
  logic [Y_WIDTH-1:0]      y1_q, y2_q;
  logic                    start_q;
  logic                    busy_q;
  logic [REQUESTERS-1:0]   ack_q, done_q;
  logic [ID_WIDTH-1:0]     grant_q, last_q;

  logic [ID_WIDTH-1:0]     pick_winner;
  logic                    pick_found;
  logic [X_WIDTH-1:0]      x1_d, x2_d;
  logic [Y_WIDTH-1:0]      y1_d, y2_d;

  function automatic logic [X_WIDTH-1:0] sat_x(input logic [X_WIDTH-1:0] v);
    if (int'(v) >= HOR_ACTIVE_PIXELS) return X_WIDTH'(HOR_ACTIVE_PIXELS - 1);
    return v;
  endfunction

  function automatic logic [Y_WIDTH-1:0] sat_y(input logic [Y_WIDTH-1:0] v);
    if (int'(v) >= VER_ACTIVE_PIXELS) return Y_WIDTH'(VER_ACTIVE_PIXELS - 1);
    return v;
  endfunction

  rr_picker #(.N(REQUESTERS)) u_picker (
    .req_i    (req_valid),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .found_o  (pick_found)
  );

  assign x1_d = sat_x(req_x1[int'(pick_winner)*X_WIDTH +: X_WIDTH]);
  assign x2_d = sat_x(req_x2[int'(pick_winner)*X_WIDTH +: X_WIDTH]);
  assign y1_d = sat_y(req_y1[int'(pick_winner)*Y_WIDTH +: Y_WIDTH]);
  assign y2_d = sat_y(req_y2[int'(pick_winner)*Y_WIDTH +: Y_WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(REQUESTERS - 1);
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          // The cycle showing req_done is a dead cycle: no grant there.
          if (line_drawer_ready && pick_found && (done_q == '0)) begin
            x1_q               <= x1_d;
            x2_q               <= x2_d;
            y1_q               <= y1_d;
            y2_q               <= y2_d;
            start_q            <= 1'b1;
            ack_q[pick_winner] <= 1'b1;
            grant_q            <= pick_winner;
            last_q             <= pick_winner;
            busy_q             <= 1'b1;
            state_q            <= ST_WAIT_1;
          end
        end
        ST_WAIT_1: begin
          // Drawer may not have dropped ready yet, so it is ignored here.
          state_q <= ST_WAIT_2;
        end
        ST_WAIT_2: begin
          if (line_drawer_ready) begin
            done_q[grant_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign x1                = x1_q;
  assign x2                = x2_q;
  assign y1                = y1_q;
  assign y2                = y2_q;
  assign line_drawer_start = start_q;
  assign req_ack           = ack_q;
  assign req_done          = done_q;
  assign busy              = busy_q;
  assign grant_id          = grant_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_line_drawer_arbiter.sv
// Directed bench for line_drawer_arbiter with two requesters: hand-computed
// expectations, a negedge monitor logging starts/acks/dones, one summary line.
module tb_line_drawer_arbiter;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*XW-1:0] req_x1, req_x2;
  logic [NR*YW-1:0] req_y1, req_y2;
  logic [NR-1:0]   req_ack, req_done;
  logic [XW-1:0]   x1, x2;
  logic [YW-1:0]   y1, y2;
  logic            line_drawer_start;
  logic            line_drawer_ready;
  logic            busy;
  logic [0:0]      grant_id;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor records
  int ncyc = 0;
  int start_cyc[$];
  int grant_log[$];
  int x1_log[$];
  int ack_cnt[NR];
  int done_cnt[NR];
  int viol = 0;
  logic [31:0] exp_q[$];

  line_drawer_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_x1            (req_x1),
    .req_x2            (req_x2),
    .req_y1            (req_y1),
    .req_y2            (req_y2),
    .req_ack           (req_ack),
    .req_done          (req_done),
    .x1                (x1),
    .x2                (x2),
    .y1                (y1),
    .y2                (y2),
    .line_drawer_start (line_drawer_start),
    .line_drawer_ready (line_drawer_ready),
    .busy              (busy),
    .grant_id          (grant_id),
    .dbg_state         (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i]  = 0;
      done_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    ncyc++;
    if (line_drawer_start) begin
      start_cyc.push_back(ncyc);
      grant_log.push_back(int'(grant_id));
      x1_log.push_back(int'(x1));
    end
    for (int i = 0; i < NR; i++) begin
      ack_cnt[i]  += int'(req_ack[i]);
      done_cnt[i] += int'(req_done[i]);
    end
    if ($countones(req_ack) > 1 || $countones(req_done) > 1 || (req_ack & req_done) != '0)
      viol++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int ax1, input int ay1, input int ax2, input int ay2);
    req_x1[i*XW +: XW] = XW'(ax1);
    req_y1[i*YW +: YW] = YW'(ay1);
    req_x2[i*XW +: XW] = XW'(ax2);
    req_y2[i*YW +: YW] = YW'(ay2);
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      if (line_drawer_start) ok = 1'b1;
    end
  endtask

  task automatic drain(input int n);
    req_valid         = '0;
    line_drawer_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    int  a0, a1, d0, base, s;
    bit  ok;

    rst = 1'b1;
    req_valid = '0;
    req_x1 = '0; req_x2 = '0; req_y1 = '0; req_y2 = '0;
    line_drawer_ready = 1'b0;
    step();
    step();
    check("rst_x1", 32'(x1), 0);
    check("rst_x2", 32'(x2), 0);
    check("rst_y1", 32'(y1), 0);
    check("rst_y2", 32'(y2), 0);
    check("rst_start", 32'(line_drawer_start), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_done", 32'(req_done), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // Single request, drawer ready again after 5 cycles in WAIT_2
    set_req(0, 10, 20, 600, 400);
    a0 = ack_cnt[0];
    d0 = done_cnt[0];
    req_valid = 2'b01;
    line_drawer_ready = 1'b1;
    step();
    check("single_start", 32'(line_drawer_start), 1);
    check("single_ack", 32'(req_ack), 32'h1);
    check("single_x1", 32'(x1), 10);
    check("single_y1", 32'(y1), 20);
    check("single_x2", 32'(x2), 600);
    check("single_y2", 32'(y2), 400);
    check("single_grant", 32'(grant_id), 0);
    check("single_busy", 32'(busy), 1);
    req_valid = '0;
    line_drawer_ready = 1'b0;
    step();
    check("w1_start", 32'(line_drawer_start), 0);
    check("w1_ack", 32'(req_ack), 0);
    repeat (5) step();
    check("w2_no_done", 32'(req_done), 0);
    check("w2_busy", 32'(busy), 1);
    line_drawer_ready = 1'b1;
    step();
    check("single_done", 32'(req_done), 32'h1);
    check("single_idle", 32'(busy), 0);
    step();
    check("single_done_pulse", 32'(req_done), 0);
    check("single_hold_x1", 32'(x1), 10);
    step();
    check("single_ack_count", 32'(ack_cnt[0] - a0), 1);
    check("single_done_count", 32'(done_cnt[0] - d0), 1);

    // Contention after reset: 0,1,0,1 spaced exactly 4 cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 100, 50, 200, 60);
    set_req(1, 300, 70, 400, 80);
    base = grant_log.size();
    line_drawer_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 40 && grant_log.size() < base + 4; k++) step();
    req_valid = '0;
    check("cont_four_starts", 32'(grant_log.size() >= base + 4), 1);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    if (grant_log.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] eg;
        eg = exp_q.pop_front();
        check($sformatf("cont_grant%0d", i), 32'(grant_log[base+i]), eg);
        check($sformatf("cont_x1_%0d", i), 32'(x1_log[base+i]), (eg == 0) ? 100 : 300);
        if (i > 0)
          check($sformatf("cont_gap%0d", i), 32'(start_cyc[base+i] - start_cyc[base+i-1]), 4);
      end
    end
    drain(10);

    // Saturation on capture (last=1, so requester 0 is searched first)
    set_req(0, 700, 500, 640, 478);
    req_valid = 2'b01;
    wait_start(10, ok);
    check("sat_started", 32'(ok), 1);
    check("sat_x1", 32'(x1), 639);
    check("sat_y1", 32'(y1), 479);
    check("sat_x2", 32'(x2), 639);
    check("sat_y2", 32'(y2), 478);
    check("sat_grant", 32'(grant_id), 0);
    drain(10);

    // Busy drawer: 20 idle cycles with requests pending and ready low
    line_drawer_ready = 1'b0;
    req_valid = 2'b11;
    s = 0;
    repeat (20) begin
      step();
      if (line_drawer_start) s++;
      if (req_ack != '0) s++;
    end
    check("busy_no_grant", 32'(s), 0);
    line_drawer_ready = 1'b1;
    step();
    check("busy_start", 32'(line_drawer_start), 1);
    check("busy_grant", 32'(grant_id), 1);
    check("busy_ack", 32'(req_ack), 32'h2);
    drain(10);

    // Reset while parked in WAIT_2
    set_req(0, 11, 22, 33, 44);
    req_valid = 2'b01;
    line_drawer_ready = 1'b1;
    step();
    check("rw2_start", 32'(line_drawer_start), 1);
    req_valid = '0;
    line_drawer_ready = 1'b0;
    step();
    step();
    step();
    check("rw2_busy", 32'(busy), 1);
    d0 = done_cnt[0] + done_cnt[1];
    rst = 1'b1;
    line_drawer_ready = 1'b1;
    step();
    check("rw2_x1", 32'(x1), 0);
    check("rw2_y2", 32'(y2), 0);
    check("rw2_busy0", 32'(busy), 0);
    check("rw2_done", 32'(req_done), 0);
    check("rw2_state", 32'(dbg_state), 0);
    rst = 1'b0;
    req_valid = 2'b11;
    step();
    check("rw2_next_start", 32'(line_drawer_start), 1);
    check("rw2_next_grant", 32'(grant_id), 0);
    check("rw2_next_ack", 32'(req_ack), 32'h1);
    check("rw2_no_done_pulse", 32'(done_cnt[0] + done_cnt[1] - d0), 0);
    drain(10);

    // Withdrawal: requester 1 raises then drops while 0 is served
    set_req(0, 1, 2, 3, 4);
    set_req(1, 5, 6, 7, 8);
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    req_valid = 2'b01;
    line_drawer_ready = 1'b1;
    step();
    check("wd_grant", 32'(grant_id), 0);
    req_valid = 2'b11;
    line_drawer_ready = 1'b0;
    step();
    step();
    step();
    req_valid = 2'b00;
    line_drawer_ready = 1'b1;
    step();
    check("wd_done", 32'(req_done), 32'h1);
    repeat (12) step();
    check("wd_ack1_never", 32'(ack_cnt[1] - a1), 0);
    check("wd_ack0_once", 32'(ack_cnt[0] - a0), 1);

    check("onehot_violations", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
